// File: rtl/sctl_if.sv
// sctl_if: SPI-side and memory-side signal bundle of the sctl controller.
// slave modport is the controller's view; master modport is the PHY + memory side.
interface sctl_if #(
    parameter int AW = 24
);
    logic          c_en;
    logic [7:0]    c_si;
    logic [7:0]    c_so;
    logic [3:0]    c_se;
    logic [AW-1:0] m_addr;
    logic          m_rd;
    logic [7:0]    m_rdata;
    logic          m_wr;
    logic [7:0]    m_wdata;
    logic          err;

    modport slave (
        input  c_en, c_si, m_rdata,
        output c_so, c_se, m_addr, m_rd, m_wr, m_wdata, err
    );

    modport master (
        output c_en, c_si, m_rdata,
        input  c_so, c_se, m_addr, m_rd, m_wr, m_wdata, err
    );
endinterface

// File: rtl/sctl.sv
// sctl: quad-DDR SPI slave protocol controller (c_ck domain, downstream of the pad PHY).
// Decodes opcode / 24-bit address / dummy / data phases and drives a simple
// synchronous memory port with 1-cycle read latency.
// Optional: define SCTL_PAGE_WRAP_EN to make address increments wrap inside a
// 256-byte page; otherwise the 24-bit counter increments linearly.
module sctl #(
    parameter int         AW    = 24,
    parameter int         DUMMY = 2,
    parameter logic [7:0] ID    = 8'hA5
) (
    input  logic   c_ck,
    input  logic   c_nrst,
    sctl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_TX, S_IGNORE
    } state_t;

    // Frame cycle index of the final dummy cycle (address bytes occupy 1..3).
    localparam logic [4:0] LAST_DUMMY = 5'(3 + DUMMY);

    state_t      state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] sh_q, sh_d;       // holds the first two address bytes until the third arrives
    logic [4:0]  cnt_q, cnt_d;     // frame cycle counter, saturating
    logic        err_q, err_d;
    logic        wseen_q, wseen_d;
    logic        rd_op_q, rd_op_d; // ADDR path: 1 = READ, 0 = WRITE
    logic        st_op_q, st_op_d; // TX path: 1 = STATUS, 0 = READ_ID
    logic [7:0]  tx_q, tx_d;       // byte repeated during a TX frame

    logic [23:0] addr_inc;
    logic        rd_s;
    logic        wr_s;
    logic        drive;

`ifdef SCTL_PAGE_WRAP_EN
    assign addr_inc = {addr_q[23:8], addr_q[7:0] + 8'd1};
`else
    assign addr_inc = addr_q + 24'd1;
`endif

    // Strobes and lane enables decoded from the current state, gated by the frame enable.
    always_comb begin
        rd_s  = 1'b0;
        wr_s  = 1'b0;
        drive = 1'b0;
        if (bus.c_en) begin
            case (state_q)
                S_DUMMY: rd_s = (cnt_q == LAST_DUMMY);
                S_RDATA: begin
                    rd_s  = 1'b1;
                    drive = 1'b1;
                end
                S_WDATA: wr_s  = 1'b1;
                S_TX:    drive = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.m_rd    = rd_s;
    assign bus.m_wr    = wr_s;
    assign bus.m_wdata = bus.c_si;
    assign bus.m_addr  = addr_q[AW-1:0];
    assign bus.err     = err_q;
    assign bus.c_se    = drive ? 4'hF : 4'h0;
    // Read data passes straight through so the byte fetched last cycle goes out now.
    assign bus.c_so    = !drive ? 8'h00 : ((state_q == S_RDATA) ? bus.m_rdata : tx_q);

    // Next-state logic: opcode decode, address assembly, phase sequencing, sticky flags.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        wseen_d = wseen_q;
        rd_op_d = rd_op_q;
        st_op_d = st_op_q;
        tx_d    = tx_q;
        if (!bus.c_en) begin
            state_d = S_CMD;
            cnt_d   = 5'd0;
        end else begin
            if (cnt_q != 5'h1F) cnt_d = cnt_q + 5'd1;
            if (rd_s || wr_s)   addr_d = addr_inc;
            if (wr_s)           wseen_d = 1'b1;
            case (state_q)
                S_CMD: begin
                    case (bus.c_si)
                        8'h0B: begin state_d = S_ADDR; rd_op_d = 1'b1; end
                        8'h02: begin state_d = S_ADDR; rd_op_d = 1'b0; end
                        8'h05: begin
                            state_d = S_TX;
                            st_op_d = 1'b1;
                            tx_d    = {6'b0, wseen_q, err_q};
                        end
                        8'h9F: begin
                            state_d = S_TX;
                            st_op_d = 1'b0;
                            tx_d    = ID;
                        end
                        default: begin state_d = S_IGNORE; err_d = 1'b1; end
                    endcase
                end
                S_ADDR: begin
                    sh_d = {sh_q[7:0], bus.c_si};
                    // The counter is only replaced once the address is complete,
                    // so an aborted address phase leaves it untouched.
                    if (cnt_q == 5'd3) begin
                        addr_d  = {sh_q, bus.c_si};
                        state_d = rd_op_q ? S_DUMMY : S_WDATA;
                    end
                end
                S_DUMMY: if (cnt_q == LAST_DUMMY) state_d = S_RDATA;
                S_TX: begin
                    // STATUS is read-to-clear once its first byte has been shifted out.
                    if (st_op_q && cnt_q == 5'd1) begin
                        err_d   = 1'b0;
                        wseen_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge c_ck or negedge c_nrst) begin
        if (!c_nrst) begin
            state_q <= S_CMD;
            addr_q  <= 24'd0;
            sh_q    <= 16'd0;
            cnt_q   <= 5'd0;
            err_q   <= 1'b0;
            wseen_q <= 1'b0;
            rd_op_q <= 1'b0;
            st_op_q <= 1'b0;
            tx_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            wseen_q <= wseen_d;
            rd_op_q <= rd_op_d;
            st_op_q <= st_op_d;
            tx_q    <= tx_d;
        end
    end
endmodule

// File: tb/tb_sctl.sv
// tb_sctl: scoreboard bench for sctl. Expected read/TX bytes and write
// transactions are queued when a frame is driven and popped as the DUT emits them.
module tb_sctl;
    localparam int DUMMY = 2;

    typedef struct packed {
        logic [23:0] a;
        logic [7:0]  d;
    } wr_t;

    logic c_ck;
    logic c_nrst;
    sctl_if #(.AW(24)) bus ();

    sctl #(.AW(24), .DUMMY(DUMMY), .ID(8'hA5)) dut (
        .c_ck   (c_ck),
        .c_nrst (c_nrst),
        .bus    (bus)
    );

    logic [7:0] mem [0:1023];
    logic [7:0] exp_rd_q [$];
    wr_t        exp_wr_q [$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         rd_seen = 0;
    int         wr_seen = 0;

    initial c_ck = 1'b0;
    always #5 c_ck = ~c_ck;

    // Synchronous memory with 1-cycle read latency.
    always @(posedge c_ck) begin
        if (bus.m_rd) bus.m_rdata <= mem[bus.m_addr[9:0]];
        if (bus.m_wr) mem[bus.m_addr[9:0]] <= bus.m_wdata;
    end

    function automatic logic [7:0] pat(input logic [9:0] a);
        return 8'(a * 10'd37) ^ 8'h5A;
    endfunction

    function automatic logic [23:0] next_a(input logic [23:0] a);
`ifdef SCTL_PAGE_WRAP_EN
        return {a[23:8], 8'(a[7:0] + 8'd1)};
`else
        return a + 24'd1;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One frame cycle: drive after the active edge, observe on the falling edge.
    task automatic step(input logic en, input logic [7:0] si);
        wr_t        w;
        logic [7:0] e;
        @(posedge c_ck);
        #1;
        bus.c_en = en;
        bus.c_si = si;
        @(negedge c_ck);
        check("rd_wr_excl", 32'(bus.m_rd & bus.m_wr), 0);
        if (bus.m_rd) rd_seen++;
        if (bus.m_wr) begin
            wr_seen++;
            check("wr_expected", 32'(exp_wr_q.size() != 0), 1);
            if (exp_wr_q.size() != 0) begin
                w = exp_wr_q.pop_front();
                check("wr_addr", 32'(bus.m_addr), 32'(w.a));
                check("wr_data", 32'(bus.m_wdata), 32'(w.d));
                $display("write addr=%06h data=%02h", bus.m_addr, bus.m_wdata);
            end
        end
        if (bus.c_se != 4'h0) begin
            check("se_full", 32'(bus.c_se), 32'hF);
            check("so_expected", 32'(exp_rd_q.size() != 0), 1);
            if (exp_rd_q.size() != 0) begin
                e = exp_rd_q.pop_front();
                check("so_byte", 32'(bus.c_so), 32'(e));
                $display("tx byte=%02h", bus.c_so);
            end
        end else begin
            check("so_zero_hiz", 32'(bus.c_so), 0);
        end
    endtask

    task automatic wr_frame(input logic [23:0] a0, input int n, input logic [7:0] d0);
        logic [23:0] a;
        wr_t         w;
        a = a0;
        rd_seen = 0;
        wr_seen = 0;
        for (int k = 0; k < n; k++) begin
            w.a = a;
            w.d = 8'(d0 + 8'(k * 17));
            exp_wr_q.push_back(w);
            a = next_a(a);
        end
        step(1'b1, 8'h02);
        step(1'b1, a0[23:16]);
        step(1'b1, a0[15:8]);
        step(1'b1, a0[7:0]);
        for (int k = 0; k < n; k++) step(1'b1, 8'(d0 + 8'(k * 17)));
        step(1'b0, 8'h00);
        check("wr_left", 32'(exp_wr_q.size()), 0);
        check("wr_count", 32'(wr_seen), 32'(n));
        check("wr_no_rd", 32'(rd_seen), 0);
    endtask

    task automatic rd_frame(input logic [23:0] a0, input int n);
        logic [23:0] a;
        a = a0;
        rd_seen = 0;
        wr_seen = 0;
        for (int k = 0; k < n; k++) begin
            exp_rd_q.push_back(pat(a[9:0]));
            a = next_a(a);
        end
        step(1'b1, 8'h0B);
        step(1'b1, a0[23:16]);
        step(1'b1, a0[15:8]);
        step(1'b1, a0[7:0]);
        for (int k = 1; k <= DUMMY; k++) begin
            step(1'b1, 8'hC3);
            check("dummy_se", 32'(bus.c_se), 0);
            check("dummy_rd", 32'(bus.m_rd), (k == DUMMY) ? 1 : 0);
        end
        check("dummy_addr", 32'(bus.m_addr), 32'(a0));
        for (int k = 0; k < n; k++) step(1'b1, 8'h3C);
        step(1'b0, 8'h00);
        check("rd_left", 32'(exp_rd_q.size()), 0);
        check("rd_count", 32'(rd_seen), 32'(n + 1));
        check("rd_no_wr", 32'(wr_seen), 0);
    endtask

    task automatic tx_frame(input logic [7:0] op, input logic [7:0] exp, input int n);
        rd_seen = 0;
        wr_seen = 0;
        for (int k = 0; k < n; k++) exp_rd_q.push_back(exp);
        step(1'b1, op);
        for (int k = 0; k < n; k++) step(1'b1, 8'h00);
        step(1'b0, 8'h00);
        check("tx_left", 32'(exp_rd_q.size()), 0);
        check("tx_no_mem", 32'(rd_seen + wr_seen), 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = pat(10'(i));
        c_nrst   = 1'b0;
        bus.c_en = 1'b0;
        bus.c_si = 8'h00;
        repeat (2) @(posedge c_ck);
        @(negedge c_ck);
        check("rst_se",   32'(bus.c_se), 0);
        check("rst_so",   32'(bus.c_so), 0);
        check("rst_rd",   32'(bus.m_rd), 0);
        check("rst_wr",   32'(bus.m_wr), 0);
        check("rst_addr", 32'(bus.m_addr), 0);
        check("rst_err",  32'(bus.err), 0);
        c_nrst = 1'b1;

        // Read across the 0x1FF boundary before anything is written there.
        rd_frame(24'h0001FE, 3);
        // Write 11,22,33 starting at 0x1FE.
        wr_frame(24'h0001FE, 3, 8'h11);
        // Top-of-space increment.
        wr_frame(24'hFFFFFF, 2, 8'h40);
        // Page-edge write: 0x1FF then the next two addresses.
        wr_frame(24'h0001FF, 3, 8'h70);

        // Unknown opcode: no drive, no strobes, sticky error.
        rd_seen = 0;
        wr_seen = 0;
        step(1'b1, 8'h77);
        step(1'b1, 8'h0B);
        step(1'b1, 8'h02);
        step(1'b0, 8'h00);
        check("ign_err", 32'(bus.err), 1);
        check("ign_no_mem", 32'(rd_seen + wr_seen), 0);

        // STATUS reports wseen|err, then reads as clear.
        tx_frame(8'h05, 8'h03, 2);
        check("status_clr_err", 32'(bus.err), 0);
        tx_frame(8'h05, 8'h00, 2);

        // Abort mid-address, then READ_ID.
        rd_seen = 0;
        wr_seen = 0;
        step(1'b1, 8'h0B);
        step(1'b1, 8'h00);
        step(1'b1, 8'h01);
        step(1'b0, 8'h00);
        check("abort_no_mem", 32'(rd_seen + wr_seen), 0);
        tx_frame(8'h9F, 8'hA5, 3);

        // Asynchronous reset during the read data phase.
        exp_rd_q.push_back(pat(10'h010));
        step(1'b1, 8'h0B);
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        step(1'b1, 8'h10);
        for (int k = 0; k < DUMMY; k++) step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        @(posedge c_ck);
        #2;
        check("pre_rst_se", 32'(bus.c_se), 32'hF);
        c_nrst = 1'b0;
        #1;
        check("arst_se",   32'(bus.c_se), 0);
        check("arst_so",   32'(bus.c_so), 0);
        check("arst_rd",   32'(bus.m_rd), 0);
        check("arst_addr", 32'(bus.m_addr), 0);
        bus.c_en = 1'b0;
        repeat (2) @(negedge c_ck);
        c_nrst = 1'b1;
        check("arst_left", 32'(exp_rd_q.size()), 0);
        tx_frame(8'h9F, 8'hA5, 2);
        check("post_rst_err", 32'(bus.err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
